param_pio: RTL
==============

PARAM_PIO -- requirements
Module: param_pio

Interface
REQ-001 Parameter WIDTH, default 27: port and register width in bits; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 117440512 (0x7000000): reset value of the output register; bits above WIDTH ignored.
REQ-003 Parameter EDGE_TYPE, default 0: edge-capture mode; 0 rising, 1 falling, 2 any edge.
REQ-004 Port clk  input  1: sole clock; all registers rise-edge triggered.
REQ-005 Port reset_n  input  1: asynchronous, active-low reset.
REQ-006 Port address  input  3: Avalon-MM word address.
REQ-007 Port chipselect  input  1: slave select.
REQ-008 Port write_n  input  1: active-low write strobe; write occurs when chipselect=1 and write_n=0.
REQ-009 Port writedata  input  32: write data; bits [31:WIDTH] ignored.
REQ-010 Port readdata  output  32: combinational read data; bits [31:WIDTH] always 0.
REQ-011 Port in_port  input  WIDTH: asynchronous external inputs.
REQ-012 Port out_port  output  WIDTH: driven directly from the output register.
REQ-013 Port irq  output  1: level interrupt, active high.

Function
REQ-014 The register map SHALL be: 0 input data (RO); 1 output data (RW); 2 irq mask (RW); 3 edge capture (R, write-1-to-clear); 4 outset (WO); 5 outclear (WO); 6-7 reserved.
REQ-015 Reads SHALL have zero wait states: readdata is a combinational function of address and register state; chipselect does not gate readdata.
REQ-016 Reads of addresses 4-7 SHALL return 0; writes to addresses 0, 6, 7 SHALL have no effect.
REQ-017 A write to address 1 SHALL load writedata[WIDTH-1:0] into the output register on the next clk edge; out_port changes one cycle after the write cycle.
REQ-018 A write to address 4 SHALL OR writedata into the output register; a write to address 5 SHALL AND the output register with ~writedata.
REQ-019 A write to address 2 SHALL load the irq mask; mask bit 1 enables that bit's capture to raise irq.
REQ-020 in_port SHALL pass through a 2-flop synchronizer; address 0 returns the second synchronizer stage.
REQ-021 A third stage (previous synchronized value) SHALL feed per-bit edge detection per EDGE_TYPE.
REQ-022 A detected edge SHALL set the corresponding edge-capture bit one cycle after detection; bits remain set (sticky) until cleared.
REQ-023 A write to address 3 SHALL clear each capture bit whose writedata bit is 1; writedata 0 bits leave capture bits unchanged.
REQ-024 If an edge on bit n is detected in the same cycle as a clear of bit n, set SHALL win: the bit remains 1.
REQ-025 irq SHALL equal OR-reduce(edge_capture & irq_mask), combinationally from registers; no extra latency beyond REQ-022.
REQ-026 Latency from in_port transition to edge-capture bit set SHALL be exactly 3 clk edges (2 synchronizer + 1 capture), and to irq, 3 edges when masked in.
REQ-027 Only address bits [2:0] SHALL be decoded; no aliasing beyond the 8-word window.

Reset
REQ-028 While reset_n=0: output register = RESET_VALUE[WIDTH-1:0], irq mask = 0, edge capture = 0, all synchronizer stages = 0, irq = 0.
REQ-029 Reset SHALL take effect asynchronously mid-operation, discarding any in-flight write or pending edge; release is synchronous to clk by the system.
REQ-030 Synchronizer stages reset to 0, so an in_port bit held at 1 through reset release SHALL produce one rising edge (EDGE_TYPE 0 or 2) after release; software clears it.

Verification
REQ-031 Reset with defaults -> out_port=0x7000000, read addr1 = 0x07000000, addr2=0, addr3=0, irq=0.
REQ-032 Write addr1 0xFFFFFFFF then addr5 0x00000F0F, then addr4 0x1 -> readback addr1 = 0x7FFF0F1 after final write, upper readdata bits 0.
REQ-033 EDGE_TYPE=0, mask 0x1, in_port[0] 0->1 at cycle t -> addr3 bit0=1 and irq=1 from edge t+3; 1->0 produces no further capture.
REQ-034 Edge on bit 0 coincident with write addr3 0x1 -> bit0 remains 1, irq stays high; subsequent clear without edge -> bit0=0, irq=0.
REQ-035 EDGE_TYPE=2, WIDTH=8, toggle in_port[7] twice -> capture bit7 set, mask 0 keeps irq=0; mask 0x80 raises irq combinationally the cycle after mask write.
REQ-036 Assert reset_n mid-write of addr1 -> out_port returns to RESET_VALUE immediately, capture and mask cleared, write discarded.

Source files
------------

// File: rtl/param_pio.sv
// Parameterized Avalon-MM parallel I/O port: output register with set/clear aliases,
// synchronized inputs, per-bit edge capture and a maskable level interrupt.
module param_pio #(
  parameter int unsigned WIDTH       = 27,
  parameter logic [31:0] RESET_VALUE = 32'h0700_0000,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    AddrData    = 3'd0,
    AddrOut     = 3'd1,
    AddrMask    = 3'd2,
    AddrCapture = 3'd3,
    AddrOutSet  = 3'd4,
    AddrOutClr  = 3'd5
  } addr_e;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, sync3_q;
  logic [WIDTH-1:0] edge_detect;
  logic [WIDTH-1:0] capture_clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_val;
  logic             wr_en;

  // Upper writedata bits are intentionally dropped.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  always_comb begin
    unique case (EDGE_TYPE)
      0:       edge_detect = sync2_q & ~sync3_q;
      1:       edge_detect = ~sync2_q & sync3_q;
      default: edge_detect = sync2_q ^ sync3_q;
    endcase
  end

  always_comb begin
    data_out_d  = data_out_q;
    irq_mask_d  = irq_mask_q;
    capture_clr = '0;
    if (wr_en) begin
      case (address)
        AddrOut:     data_out_d  = wdata;
        AddrMask:    irq_mask_d  = wdata;
        AddrCapture: capture_clr = wdata;
        AddrOutSet:  data_out_d  = data_out_q | wdata;
        AddrOutClr:  data_out_d  = data_out_q & ~wdata;
        default:     ;
      endcase
    end
    // A fresh edge overrides a simultaneous clear.
    edge_capture_d = (edge_capture_q & ~capture_clr) | edge_detect;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q     <= RESET_VALUE[WIDTH-1:0];
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      sync1_q        <= '0;
      sync2_q        <= '0;
      sync3_q        <= '0;
    end else begin
      data_out_q     <= data_out_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      sync1_q        <= in_port;
      sync2_q        <= sync1_q;
      sync3_q        <= sync2_q;
    end
  end

  always_comb begin
    case (address)
      AddrData:    rd_val = sync2_q;
      AddrOut:     rd_val = data_out_q;
      AddrMask:    rd_val = irq_mask_q;
      AddrCapture: rd_val = edge_capture_q;
      default:     rd_val = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign out_port = data_out_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
